// File: rtl/delay_sequencer.sv
// Programmable delay sequencer: turns a conditioned external trigger into up to N_CH
// gated outputs per frame, with shadowed settings that only switch on frame boundaries.
module delay_sequencer #(
    parameter int CNT_W = 16,
    parameter int N_CH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    input  logic             arm,
    input  logic             abort,
    output logic [N_CH-1:0]  ch_out,
    output logic             busy,
    output logic             frame_done,
    output logic             seq_done,
    output logic             missed,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [1:0]       dbg_state
);

    // cfg_we, arm and abort are one-cycle strobes sampled on the rising edge; there is
    // no back-pressure, so each strobe is either acted on or dropped in the cycle it is seen.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [2:0]       CTRL_ADDR = 3'd4;
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_CH-1:0]    r_ch_out;
    logic               r_frame_done;
    logic               r_seq_done;
    logic               r_missed;
    logic [CNT_W-1:0]   r_frame_cnt;

    logic               r_s1;
    logic               r_s2;
    logic               r_s3;

    logic [CNT_W-1:0]   r_sh_start [N_CH];
    logic [CNT_W-1:0]   r_sh_width [N_CH];
    logic [CNT_W-1:0]   r_sh_period;
    logic [CNT_W-1:0]   r_sh_burst;

    logic [CNT_W-1:0]   r_start [N_CH];
    logic [CNT_W-1:0]   r_width [N_CH];
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_burst;

    logic               w_trig;
    logic [CNT_W-1:0]   w_last;
    logic               w_frame_end;
    logic [CNT_W-1:0]   w_fc_next;
    logic               w_burst_hit;
    logic               w_load;
    logic [N_CH-1:0]    w_win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= pulse;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Rising edge only: a level held high yields a single trigger.
    assign w_trig = r_s2 & ~r_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                r_sh_start[k] <= '0;
                r_sh_width[k] <= '0;
            end
            r_sh_period <= '0;
            r_sh_burst  <= '0;
        end else if (cfg_we) begin
            for (int k = 0; k < N_CH; k++) begin
                if (cfg_addr == 3'(k)) begin
                    r_sh_start[k] <= cfg_wdata[CNT_W-1:0];
                    r_sh_width[k] <= cfg_wdata[16 +: CNT_W];
                end
            end
            if (cfg_addr == CTRL_ADDR) begin
                r_sh_period <= cfg_wdata[CNT_W-1:0];
                r_sh_burst  <= cfg_wdata[16 +: CNT_W];
            end
        end
    end

    // A period of zero stands for the full 2^CNT_W-cycle frame.
    assign w_last      = (r_period == '0) ? '1 : (r_period - ONE);
    assign w_frame_end = (r_cnt == w_last);
    assign w_fc_next   = (r_frame_cnt == '1) ? r_frame_cnt : (r_frame_cnt + ONE);
    assign w_burst_hit = (r_burst != '0) && (w_fc_next == r_burst);

    assign w_load = ~abort &&
                    (((r_state == ST_IDLE) && arm) ||
                     ((r_state == ST_RUN) && w_frame_end));

    // Window end is formed one bit wider so start+width never wraps.
    always_comb begin
        w_win = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_win[k] = ({1'b0, r_cnt} >= {1'b0, r_start[k]}) &&
                       ({1'b0, r_cnt} < ({1'b0, r_start[k]} + {1'b0, r_width[k]}));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                r_start[k] <= '0;
                r_width[k] <= '0;
            end
            r_period <= '0;
            r_burst  <= '0;
        end else if (w_load) begin
            for (int k = 0; k < N_CH; k++) begin
                r_start[k] <= r_sh_start[k];
                r_width[k] <= r_sh_width[k];
            end
            r_period <= r_sh_period;
            r_burst  <= r_sh_burst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_ch_out     <= '0;
            r_frame_done <= 1'b0;
            r_seq_done   <= 1'b0;
            r_missed     <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_done <= 1'b0;
            r_seq_done   <= 1'b0;
            r_ch_out     <= '0;
            if (abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (arm) begin
                            r_state     <= ST_ARMED;
                            r_missed    <= 1'b0;
                            r_frame_cnt <= '0;
                        end
                    end
                    ST_ARMED: begin
                        if (w_trig) begin
                            r_state <= ST_RUN;
                            r_cnt   <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (w_trig) begin
                            r_missed <= 1'b1;
                        end
                        // The frame leaves RUN on its last count, so outputs drop here.
                        if (w_frame_end) begin
                            r_frame_done <= 1'b1;
                            r_frame_cnt  <= w_fc_next;
                            if (w_burst_hit) begin
                                r_seq_done <= 1'b1;
                                r_state    <= ST_IDLE;
                            end else begin
                                r_state <= ST_ARMED;
                            end
                        end else begin
                            r_cnt    <= r_cnt + ONE;
                            r_ch_out <= w_win;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign ch_out     = r_ch_out;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;
    assign seq_done   = r_seq_done;
    assign missed     = r_missed;
    assign frame_cnt  = r_frame_cnt;
    assign dbg_state  = r_state;

endmodule
